rr_arbiter4: RTL

//   Four-way round-robin arbiter that sits directly upstream of encoder4to2.

---
 rtl/arb_pkg.sv | 9 +
 rtl/rr_pick.sv | 18 +
 rtl/rr_arbiter4.sv | 65 ++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared widths, FSM state type and index-to-one-hot helper for the 4-way arbiter
package arb_pkg;
  localparam int NREQ = 4;
  localparam int IDX_W = 2;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [NREQ-1:0] onehot4(input logic [IDX_W-1:0] i);
    return 4'b0001 << i;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick, first set request scanning from ptr upward modulo 4
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  logic [NREQ-1:0] rot;
  logic [IDX_W-1:0] off;
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    any = |req;
    idx = ptr + off;
  end
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter with registered one-hot grant; ARB_TIMEOUT_EN adds forced release after MAX_HOLD cycles
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic            timeout
);
  state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, owner, pick_idx;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic pick_any, rel, force_rel;
  rr_pick u_pick (.req(req), .ptr(ptr_q), .any(pick_any), .idx(pick_idx));
  assign owner = {gnt_q[3] | gnt_q[2], gnt_q[3] | gnt_q[1]};
  assign rel = done | ~|(req & gnt_q);
`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] hold_q, hold_d;
  logic timeout_q, timeout_d;
  assign force_rel = state_q == GRANT && !rel && hold_q == HOLD_LAST;
  assign hold_d = state_q == GRANT ? hold_q + 1'b1 : '0;
  assign timeout_d = force_rel;
  assign timeout = timeout_q;
  always_ff @(posedge clk) begin
    hold_q <= !rst_n ? '0 : hold_d;
    timeout_q <= !rst_n ? 1'b0 : timeout_d;
  end
`else
  assign force_rel = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    if (state_q == IDLE && pick_any) begin
      state_d = GRANT;
      gnt_d = onehot4(pick_idx);
    end else if (state_q == GRANT && (rel || force_rel)) begin
      state_d = IDLE;
      gnt_d = '0;
      ptr_d = owner + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
    end
  end
  assign gnt = gnt_q;
  assign gnt_valid = |gnt_q;
endmodule
